switch_event_arbiter: RTL and testbench
=======================================

SWITCH_EVENT_ARBITER -- requirements
Module: switch_event_arbiter

Interface
REQ-001 Parameter: RELEASE_EVENT, default 1, 1 = event on debounced 1->0 (release), 0 = event on 0->1 (press).
REQ-002 Port: i_Clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: i_Reset  input  1  synchronous, active-high reset.
REQ-004 Port: i_Switch_1..i_Switch_4  input  1 each  debounced switch levels, already synchronous to i_Clk.
REQ-005 Port: o_Event_Valid  output  1  event offered to consumer.
REQ-006 Port: o_Event_Id  output  2  source switch of offered event (0 = switch 1 ... 3 = switch 4).
REQ-007 Port: i_Event_Ready  input  1  consumer accepts the offered event.
REQ-008 Port: i_Overflow_Clr  input  1  clears all overflow flags.
REQ-009 Port: o_Overflow  output  4  sticky per-switch lost-event flags, bit n-1 = switch n.
REQ-010 Port: o_LED_1..o_LED_4  output  1 each  toggle state per switch.

Function
REQ-011 Per switch, a previous-level register shall be updated with the current input every cycle.
REQ-012 Event n shall be detected in a cycle where previous=1 and current=0 (RELEASE_EVENT=1), or previous=0 and current=1 (RELEASE_EVENT=0).
REQ-013 A detected event shall set pending[n] at that same edge.
REQ-014 Event on switch n while pending[n]=1 and not cleared that edge: pending stays 1, o_Overflow[n-1] set.
REQ-015 Event on switch n at the same edge pending[n] is cleared by acceptance: pending stays 1, no overflow.
REQ-016 FSM states: IDLE, OFFER; o_Event_Valid=1 exactly when state=OFFER.
REQ-017 IDLE, any pending=1: select winner round-robin, searching from last_grant+1 modulo 4 upward; load o_Event_Id; go to OFFER.
REQ-018 IDLE, no pending: remain IDLE, o_Event_Id holds its value.
REQ-019 OFFER, i_Event_Ready=0: hold state; o_Event_Id stable; pending unchanged for the offered switch.
REQ-020 OFFER, i_Event_Ready=1: clear pending[o_Event_Id]; last_grant <= o_Event_Id; toggle o_LED for that switch; return to IDLE.
REQ-021 Latency: input change sampled at edge E0 -> pending at E0 -> o_Event_Valid high after E1.
REQ-022 Throughput: max one accepted event per 2 cycles (mandatory IDLE cycle between offers).
REQ-023 i_Event_Ready in IDLE shall be ignored.
REQ-024 i_Overflow_Clr=1 clears all o_Overflow bits; a new overflow at the same edge shall leave its bit set (set wins).
REQ-025 Fairness: with all four pending continuously, grants rotate 0,1,2,3,0...; no switch waits more than 3 other grants.

Reset
REQ-026 While i_Reset=1: state IDLE, o_Event_Valid=0, o_Event_Id=0, pending=0, o_Overflow=0, o_LED_1..4=0, last_grant=3 (switch 1 highest priority first).
REQ-027 While i_Reset=1, previous-level registers shall load the current inputs, so no event is detected on the first cycle after reset.
REQ-028 Reset asserted in OFFER: o_Event_Valid low after that edge; offered and pending events discarded, no LED toggle.

Verification
REQ-029 Single release: switch 2 held 1, drop to 0, Ready=1 -> Valid 2 cycles later with Id=1 for 1 cycle; o_LED_2 0->1; o_Overflow=0.
REQ-030 Simultaneous releases of all four after reset, Ready=1 -> Ids 0,1,2,3 on alternating cycles; all LEDs =1.
REQ-031 Backpressure: Ready=0 for 10 cycles during offer of Id=2 -> Valid and Id=2 held stable; accepted on first Ready=1 cycle.
REQ-032 Overflow: Ready=0, switch 3 released twice -> o_Overflow=4'b0100; one event delivered; i_Overflow_Clr pulse -> o_Overflow=0.
REQ-033 Reset mid-offer: Valid=1, Id=0, assert i_Reset -> Valid=0, LEDs=0; switch held 1 through reset produces no event.
REQ-034 RELEASE_EVENT=0: switch 4 0->1 -> event Id=3; subsequent 1->0 -> no event.

Source files
------------

// File: rtl/switch_event_arbiter_if.sv
// switch_event_arbiter_if: offer/accept handshake between the arbiter and its event consumer
interface switch_event_arbiter_if;
  logic       o_Event_Valid;
  logic [1:0] o_Event_Id;
  logic       i_Event_Ready;
  modport master (output o_Event_Valid, o_Event_Id, input i_Event_Ready);
  modport slave (input o_Event_Valid, o_Event_Id, output i_Event_Ready);
endinterface

// File: rtl/switch_event_arbiter.sv
// switch_event_arbiter: edge-detects four switches and offers one event at a time, round-robin
module switch_event_arbiter #(
  parameter bit RELEASE_EVENT = 1'b1
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset,
  input  logic                          i_Switch_1,
  input  logic                          i_Switch_2,
  input  logic                          i_Switch_3,
  input  logic                          i_Switch_4,
  switch_event_arbiter_if.master        evt,
  input  logic                          i_Overflow_Clr,
  output logic [3:0]                    o_Overflow,
  output logic                          o_LED_1,
  output logic                          o_LED_2,
  output logic                          o_LED_3,
  output logic                          o_LED_4
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t     state_q, state_d;
  logic [3:0] sw, prev_q, prev_d, pend_q, pend_d, ovf_q, ovf_d, led_q, led_d, det, clr;
  logic [1:0] id_q, id_d, last_q, last_d, win, idx;
  logic       found, accept;
  assign sw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
  always_comb begin
    prev_d = sw;
    det    = RELEASE_EVENT ? (prev_q & ~sw) : (~prev_q & sw);
    accept = (state_q == OFFER) && evt.i_Event_Ready;
    clr    = accept ? 4'b0001 << id_q : 4'b0000;
    pend_d = (pend_q & ~clr) | det;
    ovf_d  = (i_Overflow_Clr ? 4'b0000 : ovf_q) | (det & pend_q & ~clr);
    led_d  = led_q ^ clr;
    last_d = accept ? id_q : last_q;
    win    = id_q;
    idx    = last_q;
    found  = 1'b0;
    // search starts just after the last grant; offset 4 wraps to last_grant itself
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && pend_q[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    state_d = (state_q == IDLE) ? (found ? OFFER : IDLE) : (accept ? IDLE : OFFER);
    id_d    = (state_q == IDLE && found) ? win : id_q;
  end
  always_ff @(posedge i_Clk) begin
    prev_q <= prev_d;
    if (i_Reset) begin
      state_q <= IDLE;
      id_q    <= 2'd0;
      last_q  <= 2'd3;
      pend_q  <= 4'b0000;
      ovf_q   <= 4'b0000;
      led_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
    end
  end
  assign evt.o_Event_Valid = (state_q == OFFER);
  assign evt.o_Event_Id    = id_q;
  assign o_Overflow        = ovf_q;
  assign {o_LED_4, o_LED_3, o_LED_2, o_LED_1} = led_q;
endmodule

// File: tb/tb_switch_event_arbiter.sv
// tb_switch_event_arbiter: directed scenarios with a scoreboard of expected accepted event ids
module tb_switch_event_arbiter;
  logic       clk = 1'b0, rst = 1'b1, ovf_clr = 1'b0;
  logic [3:0] sw = 4'hF, sw1 = 4'h0;
  logic [3:0] led, led1, ovf, ovf1;
  int         n_chk = 0, n_fail = 0;
  logic [1:0] exp_q[$];
  switch_event_arbiter_if ifc();
  switch_event_arbiter_if ifc1();
  always #5 clk = ~clk;
  switch_event_arbiter #(.RELEASE_EVENT(1'b1)) u_rel (
    .i_Clk(clk), .i_Reset(rst),
    .i_Switch_1(sw[0]), .i_Switch_2(sw[1]), .i_Switch_3(sw[2]), .i_Switch_4(sw[3]),
    .evt(ifc.master), .i_Overflow_Clr(ovf_clr), .o_Overflow(ovf),
    .o_LED_1(led[0]), .o_LED_2(led[1]), .o_LED_3(led[2]), .o_LED_4(led[3])
  );
  switch_event_arbiter #(.RELEASE_EVENT(1'b0)) u_prs (
    .i_Clk(clk), .i_Reset(rst),
    .i_Switch_1(sw1[0]), .i_Switch_2(sw1[1]), .i_Switch_3(sw1[2]), .i_Switch_4(sw1[3]),
    .evt(ifc1.master), .i_Overflow_Clr(ovf_clr), .o_Overflow(ovf1),
    .o_LED_1(led1[0]), .o_LED_2(led1[1]), .o_LED_3(led1[2]), .o_LED_4(led1[3])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!rst && ifc.o_Event_Valid && ifc.i_Event_Ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", exp_q.size(), 1);
      else chk("sb_id", ifc.o_Event_Id, exp_q.pop_front());
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    ifc.i_Event_Ready  = 1'b1;
    ifc1.i_Event_Ready = 1'b1;
    tick(2);
    chk("rst_valid", ifc.o_Event_Valid, 0);
    chk("rst_id", ifc.o_Event_Id, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_led", led, 0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_valid", ifc.o_Event_Valid, 0);
    // single release of switch 2
    sw[1] = 1'b0;
    exp_q.push_back(2'd1);
    tick(1);
    chk("single_e0_valid", ifc.o_Event_Valid, 0);
    tick(1);
    chk("single_valid", ifc.o_Event_Valid, 1);
    chk("single_id", ifc.o_Event_Id, 1);
    tick(1);
    chk("single_drop", ifc.o_Event_Valid, 0);
    chk("single_led", led, 4'b0010);
    chk("single_ovf", ovf, 0);
    sw[1] = 1'b1;
    tick(2);
    // all four released together after a fresh reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    sw = 4'h0;
    for (int k = 0; k < 4; k++) exp_q.push_back(2'(k));
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      chk("rr_valid", ifc.o_Event_Valid, (k % 2 == 0));
    end
    chk("rr_led", led, 4'b1111);
    chk("rr_ovf", ovf, 0);
    sw = 4'hF;
    tick(2);
    // backpressure on switch 3
    ifc.i_Event_Ready = 1'b0;
    sw[2] = 1'b0;
    exp_q.push_back(2'd2);
    tick(2);
    chk("bp_valid", ifc.o_Event_Valid, 1);
    chk("bp_id", ifc.o_Event_Id, 2);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("bp_hold_valid", ifc.o_Event_Valid, 1);
      chk("bp_hold_id", ifc.o_Event_Id, 2);
    end
    ifc.i_Event_Ready = 1'b1;
    tick(1);
    chk("bp_accept", ifc.o_Event_Valid, 0);
    chk("bp_led", led, 4'b1011);
    sw[2] = 1'b1;
    tick(2);
    // overflow on switch 3, then clear with a coincident new overflow
    ifc.i_Event_Ready = 1'b0;
    sw[2] = 1'b0;
    tick(1);
    sw[2] = 1'b1;
    tick(1);
    sw[2] = 1'b0;
    tick(1);
    chk("ovf_set", ovf, 4'b0100);
    chk("ovf_valid", ifc.o_Event_Valid, 1);
    chk("ovf_id", ifc.o_Event_Id, 2);
    sw[2] = 1'b1;
    tick(1);
    sw[2]   = 1'b0;
    ovf_clr = 1'b1;
    tick(1);
    chk("ovf_set_wins", ovf, 4'b0100);
    tick(1);
    chk("ovf_clr", ovf, 0);
    ovf_clr = 1'b0;
    exp_q.push_back(2'd2);
    ifc.i_Event_Ready = 1'b1;
    tick(1);
    chk("ovf_accept", ifc.o_Event_Valid, 0);
    chk("ovf_led", led, 4'b1111);
    tick(2);
    chk("ovf_single", ifc.o_Event_Valid, 0);
    sw[2] = 1'b1;
    tick(2);
    // new event on switch 4 in the same edge as its acceptance
    ifc.i_Event_Ready = 1'b0;
    sw[3] = 1'b0;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    tick(2);
    chk("same_valid", ifc.o_Event_Valid, 1);
    chk("same_id", ifc.o_Event_Id, 3);
    sw[3] = 1'b1;
    tick(1);
    ifc.i_Event_Ready = 1'b1;
    sw[3] = 1'b0;
    tick(1);
    chk("same_idle", ifc.o_Event_Valid, 0);
    chk("same_ovf", ovf, 0);
    tick(1);
    chk("same_reoffer", ifc.o_Event_Valid, 1);
    chk("same_reid", ifc.o_Event_Id, 3);
    tick(1);
    chk("same_done", ifc.o_Event_Valid, 0);
    chk("same_led", led, 4'b1111);
    sw[3] = 1'b1;
    tick(2);
    // reset while offering switch 1
    ifc.i_Event_Ready = 1'b0;
    sw[0] = 1'b0;
    tick(2);
    chk("mid_valid", ifc.o_Event_Valid, 1);
    chk("mid_id", ifc.o_Event_Id, 0);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_valid", ifc.o_Event_Valid, 0);
    chk("mid_rst_id", ifc.o_Event_Id, 0);
    chk("mid_rst_led", led, 0);
    chk("mid_rst_ovf", ovf, 0);
    sw[1] = 1'b0;
    ifc.i_Event_Ready = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("mid_no_event", ifc.o_Event_Valid, 0);
    end
    chk("mid_led", led, 0);
    sw = 4'hF;
    tick(2);
    // press-mode instance: rising edge is the event, falling edge is not
    sw1[3] = 1'b1;
    tick(1);
    chk("press_e0", ifc1.o_Event_Valid, 0);
    tick(1);
    chk("press_valid", ifc1.o_Event_Valid, 1);
    chk("press_id", ifc1.o_Event_Id, 3);
    tick(1);
    chk("press_done", ifc1.o_Event_Valid, 0);
    chk("press_led", led1, 4'b1000);
    sw1[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("press_release_quiet", ifc1.o_Event_Valid, 0);
    end
    chk("press_ovf", ovf1, 0);
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
